// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants.
// Used by the host transmitter and the receiver side.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_NOSTART = 2'b01,
    ERR_BITTO   = 2'b10,
    ERR_NOACK   = 2'b11
  } ps2_err_e;

  localparam logic [7:0] CMD_SETLED = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;

  // Index 10 is the device ACK slot.
  localparam logic [3:0] IDX_ACK = 4'd10;

  // Wire order after the start bit:
  // data[0..7], odd parity, stop.
  function automatic logic [9:0] ps2_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 pads with
// a registered falling-edge pulse on the clock line.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_hist_q, clk_hist_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;
  logic fall_q, fall_d;

  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_hist_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
    fall_d      = clk_hist_q & ~clk_sync_q;
  end

  // Idle bus is high; reset there so release
  // never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_hist_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_hist_q  <= clk_hist_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_sync  = clk_sync_q;
  assign data_sync = data_sync_q;
  assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibit, request-to-send, 11 device clocks, ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 50000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [CNT_W-1:0] INH_PRE =
    CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST =
    CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(BIT_TIMEOUT - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  ps2_err_e         code_q, code_d;
  logic             ready_q, ready_d;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  logic accept;
  logic inh_pre;
  logic inh_end;
  logic start_to;
  logic bit_to;
  logic ack_slot;
  logic line_idle;
  logic fall_ack;
  logic fall_bit;
  logic shift_to;

  always_comb begin
    accept    = (state_q == IDLE) & tx_valid & ready_q;
    inh_pre   = (timer_q == INH_PRE);
    inh_end   = (timer_q == INH_LAST);
    start_to  = (timer_q == START_LAST);
    bit_to    = (timer_q == BIT_LAST);
    ack_slot  = (idx_q == IDX_ACK);
    line_idle = clk_sync & data_sync;
    fall_ack  = clk_fall & ack_slot;
    fall_bit  = clk_fall & ~ack_slot;
    shift_to  = ~clk_fall & bit_to;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = INHIBIT;
      end
      INHIBIT: begin
        if (inh_end) state_d = REQ;
      end
      REQ: begin
        if (clk_fall)      state_d = SHIFT;
        else if (start_to) state_d = IDLE;
      end
      SHIFT: begin
        if (fall_ack)
          state_d = data_sync ? IDLE : WAIT_IDLE;
        else if (shift_to)
          state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (line_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d   = timer_q + CNT_W'(1);
    idx_d     = idx_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    ready_d   = (state_d == IDLE);
    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        idx_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept) begin
          frame_d  = ps2_frame(tx_data);
          clk_oe_d = 1'b1;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        // Start bit goes down while the clock is
        // still held, so it precedes the release.
        if (inh_pre) data_oe_d = 1'b1;
        if (inh_end) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
        end
      end
      REQ: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          idx_d     = 4'd1;
          timer_d   = '0;
        end else if (start_to) begin
          err_d     = 1'b1;
          code_d    = ERR_NOSTART;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      end
      SHIFT: begin
        unique case (1'b1)
          fall_ack: begin
            timer_d   = '0;
            data_oe_d = 1'b0;
            if (data_sync) begin
              err_d  = 1'b1;
              code_d = ERR_NOACK;
            end else begin
              done_d = 1'b1;
            end
          end
          fall_bit: begin
            timer_d   = '0;
            idx_d     = idx_q + 4'd1;
            data_oe_d = ~frame_q[idx_q];
          end
          shift_to: begin
            err_d     = 1'b1;
            code_d    = ERR_BITTO;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
          end
          default: ;
        endcase
      end
      WAIT_IDLE: begin
        timer_d   = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
      default: begin
        timer_d   = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_ready    = ready_q;
    busy        = (state_q != IDLE);
    rx_inhibit  = (state_q != IDLE);
    done        = done_q;
    err         = err_q;
    err_code    = code_q;
    ps2_clk_oe  = clk_oe_q;
    ps2_data_oe = data_oe_q;
  end

endmodule
